// File: rtl/gam_input_buffer_pkg.sv
// GAM_package: shared GAM types plus input-buffer sample and epoch-state types.
package GAM_package;
  localparam int NODE_COUNT = 4;
  localparam int NUM_CLASSES_DEF = 8;
  typedef logic [NODE_COUNT-1:0][7:0] node_vector_T;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN, ST_DONE} in_state_T;
  typedef struct packed {
    node_vector_T x;
    int           c;
  } sample_T;
endpackage

// File: rtl/gam_input_buffer_fifo.sv
// gam_sample_fifo: power-of-two sample FIFO with wrapping pointers and occupancy count.
module gam_sample_fifo
  import GAM_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  sample_T wdata,
  output sample_T rdata,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  sample_T mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic wr, rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[head];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr) tail <= tail + AW'(1);
      if (rd) head <= head + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  // storage needs no reset: empty masking at the top hides stale entries
  always_ff @(posedge clk)
    if (wr) mem[tail] <= wdata;
endmodule

// File: rtl/gam_input_buffer.sv
// gam_input_buffer: buffers labelled samples for the memory layer, filters bad labels,
// tracks epoch boundaries and pulses learning_done once the final sample drains.
module gam_input_buffer
  import GAM_package::*;
#(
  parameter int DEPTH       = 4,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  node_vector_T        in_x,
  input  logic signed [31:0]  in_c,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_accept,
  output node_vector_T        x,
  output logic signed [31:0]  c,
  output logic                learning_done,
  output logic                err_class,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);
  in_state_T state, state_n;
  sample_T   head;
  logic      full, empty, push_hs, legal, drop, pop, start;
  assign legal   = (in_c >= 0) && (in_c < NUM_CLASSES);
  assign push_hs = in_valid && in_ready;
  assign drop    = push_hs && !legal;
  assign pop     = out_valid && out_accept;
  assign start   = (state == ST_IDLE) && push_hs;
  gam_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_hs && legal),
    .pop   (pop),
    .wdata ('{x: in_x, c: in_c}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  assign out_valid = !empty;
  assign x         = empty ? '0 : head.x;
  assign c         = empty ? '0 : head.c;
  always_comb begin
    state_n       = state;
    in_ready      = rst_n && !full && (state == ST_IDLE || state == ST_FILL);
    learning_done = state == ST_DONE;
    case (state)
      ST_IDLE:  if (push_hs) state_n = in_last ? ST_DRAIN : ST_FILL;
      ST_FILL:  if (push_hs && in_last) state_n = ST_DRAIN;
      ST_DRAIN: if (empty) state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_IDLE;
      err_class  <= 1'b0;
      sample_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      state     <= state_n;
      err_class <= drop;
      // a new epoch restarts both counters; the queue is empty in IDLE so no pop can coincide
      if (start) begin
        sample_cnt <= '0;
        drop_cnt   <= CNT_W'(drop);
      end else begin
        if (pop && !(&sample_cnt)) sample_cnt <= sample_cnt + CNT_W'(1);
        if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_gam_input_buffer.sv
// tb_gam_input_buffer: directed checks of buffering, backpressure, label filtering and epoch control.
module tb_gam_input_buffer;
  import GAM_package::*;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  node_vector_T       in_x = '0;
  logic signed [31:0] in_c = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_accept = 1'b0;
  node_vector_T       x;
  logic signed [31:0] c;
  logic               learning_done;
  logic               err_class;
  logic [15:0]        sample_cnt;
  logic [15:0]        drop_cnt;
  int total = 0;
  int bad = 0;

  gam_input_buffer #(.DEPTH(4), .NUM_CLASSES(8), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_x          (in_x),
    .in_c          (in_c),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_accept    (out_accept),
    .x             (x),
    .c             (c),
    .learning_done (learning_done),
    .err_class     (err_class),
    .sample_cnt    (sample_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xv(input int k);
    return {8'(k + 1), 8'hA5, 8'(k * 3), 8'h5A};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int k, input logic signed [31:0] cls, input logic last);
    in_valid = v;
    in_x     = xv(k);
    in_c     = cls;
    in_last  = last;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_x", x, 0);
    chk("rst_c", c, 0);
    chk("rst_done", 32'(learning_done), 0);
    chk("rst_err", 32'(err_class), 0);
    chk("rst_scnt", 32'(sample_cnt), 0);
    chk("rst_dcnt", 32'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 32'(in_ready), 1);
    // three legal pushes, no pops
    drive(1, 0, 0, 0);
    step();
    chk("t1_valid_after_first", 32'(out_valid), 1);
    chk("t1_head_c", c, 0);
    chk("t1_head_x", x, xv(0));
    drive(1, 1, 1, 0);
    step();
    drive(1, 2, 2, 0);
    step();
    drive(0, 0, 0, 0);
    chk("t1_ready_at3", 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_stable_x", x, xv(0));
      chk("t1_stable_c", c, 0);
    end
    // fill to DEPTH, then a refused push coinciding with a pop
    drive(1, 3, 3, 0);
    step();
    chk("t2_full_ready", 32'(in_ready), 0);
    drive(1, 4, 4, 0);
    out_accept = 1'b1;
    chk("t2_refused_ready", 32'(in_ready), 0);
    step();
    drive(0, 0, 0, 0);
    out_accept = 1'b0;
    chk("t2_ready_after_pop", 32'(in_ready), 1);
    chk("t2_head_after_pop", c, 1);
    out_accept = 1'b1;
    step();
    chk("t2_drain_c2", c, 2);
    step();
    chk("t2_drain_c3", c, 3);
    chk("t2_drain_x3", x, xv(3));
    step();
    out_accept = 1'b0;
    chk("t2_empty_valid", 32'(out_valid), 0);
    chk("t2_empty_c", c, 0);
    chk("t2_scnt4", 32'(sample_cnt), 4);
    // close the epoch with a last sample
    drive(1, 5, 5, 1);
    step();
    drive(0, 0, 0, 0);
    chk("e1_drain_ready", 32'(in_ready), 0);
    out_accept = 1'b1;
    step();
    out_accept = 1'b0;
    chk("e1_not_done_yet", 32'(learning_done), 0);
    chk("e1_scnt5", 32'(sample_cnt), 5);
    step();
    chk("e1_done", 32'(learning_done), 1);
    step();
    chk("e1_done_one_cycle", 32'(learning_done), 0);
    chk("e1_idle_ready", 32'(in_ready), 1);
    chk("e1_scnt_held", 32'(sample_cnt), 5);
    // ten samples streamed with simultaneous push and pop
    out_accept = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1, k, k % 8, k == 9);
      if (k > 0) chk("t3_stream_c", c, (k - 1) % 8);
      chk("t3_stream_ready", 32'(in_ready), 1);
      step();
    end
    drive(0, 0, 0, 0);
    chk("t3_drain_ready", 32'(in_ready), 0);
    chk("t3_last_c", c, 1);
    step();
    chk("t3_empty_ready", 32'(in_ready), 0);
    chk("t3_empty_valid", 32'(out_valid), 0);
    chk("t3_done_early", 32'(learning_done), 0);
    chk("t3_scnt10", 32'(sample_cnt), 10);
    step();
    out_accept = 1'b0;
    chk("t3_done", 32'(learning_done), 1);
    chk("t3_done_ready", 32'(in_ready), 0);
    step();
    chk("t3_done_clear", 32'(learning_done), 0);
    chk("t3_idle_ready", 32'(in_ready), 1);
    chk("t3_scnt_held", 32'(sample_cnt), 10);
    chk("t3_dcnt", 32'(drop_cnt), 0);
    // illegal labels: 8, then -1 marked last on an empty queue
    drive(1, 6, 8, 0);
    step();
    chk("t4_err1", 32'(err_class), 1);
    chk("t4_dcnt1", 32'(drop_cnt), 1);
    chk("t4_scnt_clr", 32'(sample_cnt), 0);
    chk("t4_valid1", 32'(out_valid), 0);
    drive(1, 7, -1, 1);
    step();
    drive(0, 0, 0, 0);
    chk("t4_err2", 32'(err_class), 1);
    chk("t4_dcnt2", 32'(drop_cnt), 2);
    chk("t4_valid2", 32'(out_valid), 0);
    chk("t4_drain_ready", 32'(in_ready), 0);
    step();
    chk("t4_err_clear", 32'(err_class), 0);
    chk("t4_done", 32'(learning_done), 1);
    chk("t4_no_entry", 32'(out_valid), 0);
    step();
    chk("t4_done_clear", 32'(learning_done), 0);
    // illegal last label with two legal samples queued
    drive(1, 6, 6, 0);
    step();
    chk("t5_dcnt_clr", 32'(drop_cnt), 0);
    drive(1, 7, 7, 0);
    step();
    drive(1, 8, 9, 1);
    step();
    drive(0, 0, 0, 0);
    chk("t5_err", 32'(err_class), 1);
    chk("t5_dcnt1", 32'(drop_cnt), 1);
    chk("t5_drain_ready", 32'(in_ready), 0);
    chk("t5_head6", c, 6);
    out_accept = 1'b1;
    step();
    chk("t5_head7", c, 7);
    chk("t5_x7", x, xv(7));
    chk("t5_no_done1", 32'(learning_done), 0);
    step();
    out_accept = 1'b0;
    chk("t5_empty", 32'(out_valid), 0);
    chk("t5_no_done2", 32'(learning_done), 0);
    chk("t5_scnt2", 32'(sample_cnt), 2);
    step();
    chk("t5_done", 32'(learning_done), 1);
    chk("t5_dcnt_final", 32'(drop_cnt), 1);
    step();
    chk("t5_done_clear", 32'(learning_done), 0);
    // asynchronous reset mid-epoch with three queued entries
    drive(1, 1, 1, 0);
    step();
    drive(1, 2, 2, 0);
    step();
    drive(1, 3, 3, 0);
    step();
    drive(1, 4, 10, 0);
    step();
    drive(0, 0, 0, 0);
    chk("t6_pre_valid", 32'(out_valid), 1);
    chk("t6_pre_dcnt", 32'(drop_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_x", x, 0);
    chk("t6_async_c", c, 0);
    chk("t6_async_dcnt", 32'(drop_cnt), 0);
    chk("t6_async_scnt", 32'(sample_cnt), 0);
    chk("t6_async_ready", 32'(in_ready), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t6_rst_no_done", 32'(learning_done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_rel_ready", 32'(in_ready), 1);
    chk("t6_rel_valid", 32'(out_valid), 0);
    chk("t6_rel_no_done", 32'(learning_done), 0);
    step();
    chk("t6_rel_no_done2", 32'(learning_done), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
